// File: rtl/prog_mem_pkg.sv
// Shared types and default widths for the program-memory path (arbiter and I-cache).
package prog_mem_pkg;

  localparam int unsigned PROG_ADDR_BITS = 8;
  localparam int unsigned PROG_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after 'last', with wrap.
module rr_picker #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] last,
  output logic                found_c,
  output logic [IDX_BITS-1:0] grant_c
);

  int unsigned idx;

  // Scan last+1 .. last+NUM_REQ so 'last' itself has lowest priority.
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!found_c && req[IDX_BITS'(idx)]) begin
        found_c = 1'b1;
        grant_c = IDX_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Round-robin arbiter funnelling per-core I-cache miss reads onto one program-memory port.
module prog_mem_arbiter
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = PROG_ADDR_BITS,
  parameter int unsigned DATA_BITS     = PROG_DATA_BITS,
  parameter int unsigned NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  localparam int unsigned IDX_BITS = $clog2(NUM_CONSUMERS);

  arb_state_t           state;
  logic [IDX_BITS-1:0]  grant;
  logic [IDX_BITS-1:0]  rr_last;
  logic                 pick_found_c;
  logic [IDX_BITS-1:0]  pick_grant_c;
  logic [ADDR_BITS-1:0] pick_addr_c;

  rr_picker #(
    .NUM_REQ  (NUM_CONSUMERS),
    .IDX_BITS (IDX_BITS)
  ) u_picker (
    .req     (consumer_read_valid),
    .last    (rr_last),
    .found_c (pick_found_c),
    .grant_c (pick_grant_c)
  );

  // Address of the channel the picker would grant this cycle.
  always_comb begin
    pick_addr_c = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (pick_grant_c == IDX_BITS'(i)) begin
        pick_addr_c = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      grant               <= '0;
      rr_last             <= IDX_BITS'(NUM_CONSUMERS - 1);
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      consumer_read_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_found_c) begin
            grant            <= pick_grant_c;
            rr_last          <= pick_grant_c;
            mem_read_address <= pick_addr_c;
            mem_read_valid   <= 1'b1;
            state            <= WAIT;
          end
        end
        WAIT: begin
          // Completes even if the requester dropped valid meanwhile.
          if (mem_read_ready) begin
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
              if (grant == IDX_BITS'(i)) begin
                consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                consumer_read_ready[i]                       <= 1'b1;
              end
            end
            mem_read_valid <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          // Bubble lets the served consumer retire its valid before re-arbitration.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
